// File: rtl/pump_soft_start_if.sv
// Signal bundle between the irrigation interval timer side and the pump
// soft-start block: request/configuration in, motor drive and status out.
interface pump_soft_start_if;
    logic       req_n;
    logic [3:0] duty_max;
    logic       fault_clr;
    logic       pump_out;
    logic [2:0] state;
    logic       fault;

    // Timer / supervisor side drives the request and reads the status
    modport master (
        output req_n,
        output duty_max,
        output fault_clr,
        input  pump_out,
        input  state,
        input  fault
    );

    // Soft-start block side
    modport slave (
        input  req_n,
        input  duty_max,
        input  fault_clr,
        output pump_out,
        output state,
        output fault
    );
endinterface

// File: rtl/pump_soft_start.sv
// Pump soft-start: turns the timer's active-low run request into a PWM motor
// drive that ramps up in 1/16 duty steps per tick, enforces a cooldown between
// runs and latches a dry-run fault when the pump stays on too long.
module pump_soft_start #(
    parameter int TICK_DIV      = 50000000,
    parameter int MAX_ON_TICKS  = 120,
    parameter int MIN_OFF_TICKS = 10
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    pump_soft_start_if.slave bus
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ON_W   = $clog2(MAX_ON_TICKS + 1);
    localparam int OFF_W  = $clog2(MIN_OFF_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [ON_W-1:0]   ON_LIMIT  = ON_W'(MAX_ON_TICKS);
    localparam logic [OFF_W-1:0]  OFF_LIMIT = OFF_W'(MIN_OFF_TICKS);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP     = 3'd1,
        ST_RUN      = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    // Only the ramp and run states are allowed to energise the motor
    function automatic logic is_driving(input state_t s);
        return (s == ST_RAMP) || (s == ST_RUN);
    endfunction

    logic              req_n_p0;
    logic              req_n_p1;
    logic              req;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [3:0]        pwm_cnt;

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        duty_q;
    logic [3:0]        duty_d;
    logic [3:0]        dmax_q;
    logic [3:0]        dmax_d;
    logic [ON_W-1:0]   on_cnt_q;
    logic [ON_W-1:0]   on_cnt_d;
    logic [ON_W-1:0]   on_inc;
    logic [OFF_W-1:0]  off_cnt_q;
    logic [OFF_W-1:0]  off_cnt_d;
    logic [OFF_W-1:0]  off_inc;
    logic              fault_q;
    logic              fault_d;
    logic              pump_out_q;

    // Two-flop synchroniser for the asynchronous request; clears to "no request"
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            req_n_p0 <= 1'b1;
            req_n_p1 <= 1'b1;
        end else begin
            req_n_p0 <= bus.req_n;
            req_n_p1 <= req_n_p0;
        end
    end

    assign req  = ~req_n_p1;
    assign tick = (tick_cnt == TICK_LAST);

    // Free-running tick divider, independent of the FSM so ticks never drift
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // PWM phase counter, wraps 15 -> 0 every 16 clocks
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    // Next-state logic: ramp/run timing, cooldown and dry-run fault handling
    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        dmax_d    = dmax_q;
        on_cnt_d  = on_cnt_q;
        off_cnt_d = off_cnt_q;
        fault_d   = fault_q;
        on_inc    = on_cnt_q + 1'b1;
        off_inc   = off_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (req && (bus.duty_max != 4'd0)) begin
                    state_d  = ST_RAMP;
                    dmax_d   = bus.duty_max;
                    duty_d   = 4'd1;
                    on_cnt_d = '0;
                end
            end
            ST_RAMP, ST_RUN: begin
                // A dropped request wins over a fault falling on the same tick
                if (!req) begin
                    state_d   = ST_COOLDOWN;
                    off_cnt_d = '0;
                end else if (tick) begin
                    on_cnt_d = on_inc;
                    if (on_inc == ON_LIMIT) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else if (state_q == ST_RAMP) begin
                        if (duty_q == dmax_q) begin
                            state_d = ST_RUN;
                        end else begin
                            duty_d = duty_q + 4'd1;
                        end
                    end
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    off_cnt_d = off_inc;
                    if (off_inc == OFF_LIMIT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FAULT: begin
                // Clearing needs the request gone, otherwise the pump would restart straight away
                if (bus.fault_clr && !req) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered motor drive; drive follows the next state
    // so the pin drops on the very first clock a driving state is left
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            duty_q     <= 4'd0;
            dmax_q     <= 4'd0;
            on_cnt_q   <= '0;
            off_cnt_q  <= '0;
            fault_q    <= 1'b0;
            pump_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            dmax_q     <= dmax_d;
            on_cnt_q   <= on_cnt_d;
            off_cnt_q  <= off_cnt_d;
            fault_q    <= fault_d;
            pump_out_q <= is_driving(state_d) && (pwm_cnt < duty_d);
        end
    end

    assign bus.pump_out = pump_out_q;
    assign bus.state    = state_q;
    assign bus.fault    = fault_q;

endmodule
